// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - decode/EX hazard control signal bundle
interface pipeline_hazard_ctrl_if;
    logic        i_d_valid;
    logic [15:0] i_d_instr;
    logic        i_branch_taken;
    logic        i_ex_stall_req;
    logic        o_stall_fd;
    logic        o_bubble_ex;
    logic        o_flush;
    logic [1:0]  o_fwd_x;
    logic [1:0]  o_fwd_y;
    logic [15:0] o_stall_count;

    modport master (
        output i_d_valid, i_d_instr, i_branch_taken, i_ex_stall_req,
        input  o_stall_fd, o_bubble_ex, o_flush, o_fwd_x, o_fwd_y, o_stall_count
    );

    modport slave (
        input  i_d_valid, i_d_instr, i_branch_taken, i_ex_stall_req,
        output o_stall_fd, o_bubble_ex, o_flush, o_fwd_x, o_fwd_y, o_stall_count
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - load-use stall, branch flush and operand forwarding control
module pipeline_hazard_ctrl (
    input  logic                   clk,
    input  logic                   reset,
    pipeline_hazard_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {RUN, LDSTALL, FLUSH} state_t;

    typedef struct packed {
        logic       valid;
        logic       wr;
        logic [2:0] dst;
        logic       is_ld;
    } sb_entry_t;

    state_t    state, next_state;
    sb_entry_t ex_e, wb_e;
    logic [15:0] stall_count;

    logic [4:0] op;
    logic [2:0] rx, ry, d_dst;
    logic       d_wr, d_rdx, d_rdy, d_is_ld;
    logic       ld_haz;
    logic       stall_fd, bubble_ex, flush;
    logic [1:0] fwd_x, fwd_y;
    logic       unused_instr_bits;

    assign op = bus.i_d_instr[4:0];
    assign rx = bus.i_d_instr[7:5];
    assign ry = bus.i_d_instr[10:8];
    assign unused_instr_bits = ^bus.i_d_instr[15:11];

    always_comb begin
        d_wr  = 1'b0;
        d_rdx = 1'b0;
        d_rdy = 1'b0;
        case (op)
            5'b00000:                   begin d_wr = 1'b1; d_rdy = 1'b1; end
            5'b00001, 5'b00010:         begin d_wr = 1'b1; d_rdx = 1'b1; d_rdy = 1'b1; end
            5'b00011, 5'b00101:         begin d_rdx = 1'b1; d_rdy = 1'b1; end
            5'b00100:                   begin d_wr = 1'b1; d_rdy = 1'b1; end
            5'b10000:                   d_wr = 1'b1;
            5'b10001, 5'b10010, 5'b10110: begin d_wr = 1'b1; d_rdx = 1'b1; end
            5'b10011, 5'b01000, 5'b01001, 5'b01010: d_rdx = 1'b1;
            5'b01100, 5'b11100:         d_wr = 1'b1;
            default:                    ;
        endcase
    end

    // Calls link into r7 regardless of the Rx field
    assign d_dst   = (op == 5'b01100 || op == 5'b11100) ? 3'd7 : rx;
    assign d_is_ld = (op == 5'b00100);

    assign ld_haz = bus.i_d_valid && ex_e.valid && ex_e.wr && ex_e.is_ld &&
                    ((d_rdx && ex_e.dst == rx) || (d_rdy && ex_e.dst == ry));

    function automatic logic [1:0] fwd_sel(input sb_entry_t ex, input sb_entry_t wb,
                                           input logic [2:0] r);
        if (ex.valid && ex.wr && !ex.is_ld && ex.dst == r)
            return 2'b01;
        else if (wb.valid && wb.wr && wb.dst == r)
            return 2'b10;
        else
            return 2'b00;
    endfunction

    // Memory stall beats branch; branch beats the second flush slot and load-use
    always_comb begin
        stall_fd   = 1'b0;
        bubble_ex  = 1'b0;
        flush      = 1'b0;
        fwd_x      = 2'b00;
        fwd_y      = 2'b00;
        next_state = state;
        if (reset) begin
            next_state = RUN;
        end else begin
            if (bus.i_ex_stall_req) begin
                stall_fd = 1'b1;
            end else if (bus.i_branch_taken) begin
                flush      = 1'b1;
                bubble_ex  = 1'b1;
                next_state = FLUSH;
            end else if (state == FLUSH) begin
                flush      = 1'b1;
                bubble_ex  = 1'b1;
                next_state = RUN;
            end else if (ld_haz) begin
                stall_fd   = 1'b1;
                bubble_ex  = 1'b1;
                next_state = LDSTALL;
            end else begin
                next_state = RUN;
            end
            if (bus.i_d_valid) begin
                fwd_x = d_rdx ? fwd_sel(ex_e, wb_e, rx) : 2'b00;
                fwd_y = d_rdy ? fwd_sel(ex_e, wb_e, ry) : 2'b00;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= RUN;
            ex_e        <= '0;
            wb_e        <= '0;
            stall_count <= 16'd0;
        end else begin
            state <= next_state;
            if (!bus.i_ex_stall_req) begin
                wb_e <= ex_e;
                if (bus.i_d_valid && !bubble_ex && !flush)
                    ex_e <= '{valid: 1'b1, wr: d_wr, dst: d_dst, is_ld: d_is_ld};
                else
                    ex_e <= '0;
            end
            if (stall_fd && stall_count != 16'hFFFF)
                stall_count <= stall_count + 16'd1;
        end
    end

    assign bus.o_stall_fd    = stall_fd;
    assign bus.o_bubble_ex   = bubble_ex;
    assign bus.o_flush       = flush;
    assign bus.o_fwd_x       = fwd_x;
    assign bus.o_fwd_y       = fwd_y;
    assign bus.o_stall_count = stall_count;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed and random checks of pipeline_hazard_ctrl against a pipeline model
module tb_pipeline_hazard_ctrl;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if bus();

    pipeline_hazard_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Model: raw instructions occupying EX and WB, plus a pending killed decode slot
    bit          m_ex_v, m_wb_v, m_flush_next;
    logic [15:0] m_ex_i, m_wb_i;
    int          m_count;

    logic        o_st, o_bu, o_fl;
    logic [1:0]  o_fx, o_fy;
    logic [15:0] o_cnt;

    logic [4:0] pool [16] = '{5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b00100,
                              5'b00101, 5'b10000, 5'b10001, 5'b10010, 5'b10011, 5'b10110,
                              5'b01000, 5'b01010, 5'b01100, 5'b11100};

    function automatic logic [15:0] mk(input logic [4:0] op, input int x, input int y);
        logic [2:0] xs, ys;
        xs = x[2:0];
        ys = y[2:0];
        return {5'b00000, ys, xs, op};
    endfunction

    function automatic bit is_wr(input logic [4:0] op);
        return op inside {5'b00000, 5'b00001, 5'b00010, 5'b00100, 5'b10000,
                          5'b10001, 5'b10010, 5'b10110, 5'b01100, 5'b11100};
    endfunction

    function automatic bit rd_x(input logic [4:0] op);
        return op inside {5'b00001, 5'b00010, 5'b00011, 5'b00101, 5'b10001, 5'b10010,
                          5'b10011, 5'b10110, 5'b01000, 5'b01001, 5'b01010};
    endfunction

    function automatic bit rd_y(input logic [4:0] op);
        return op inside {5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b00101};
    endfunction

    function automatic int dest(input logic [15:0] ins);
        if (ins[4:0] inside {5'b01100, 5'b11100}) return 7;
        return int'(ins[7:5]);
    endfunction

    function automatic logic [1:0] m_fwd(input int r);
        if (m_ex_v && is_wr(m_ex_i[4:0]) && m_ex_i[4:0] != 5'b00100 && dest(m_ex_i) == r)
            return 2'b01;
        if (m_wb_v && is_wr(m_wb_i[4:0]) && dest(m_wb_i) == r)
            return 2'b10;
        return 2'b00;
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ex_v = 0; m_wb_v = 0; m_flush_next = 0; m_count = 0;
        m_ex_i = '0; m_wb_i = '0;
    endtask

    task automatic capture();
        o_st = bus.o_stall_fd; o_bu = bus.o_bubble_ex; o_fl = bus.o_flush;
        o_fx = bus.o_fwd_x;    o_fy = bus.o_fwd_y;     o_cnt = bus.o_stall_count;
    endtask

    task automatic step(input bit v, input logic [15:0] ins, input bit br, input bit st);
        bit e_st, e_bu, e_fl, haz;
        logic [1:0] e_fx, e_fy;
        logic [4:0] op;
        int rx, ry;
        @(negedge clk);
        bus.i_d_valid = v; bus.i_d_instr = ins; bus.i_branch_taken = br; bus.i_ex_stall_req = st;
        #2;
        capture();
        op = ins[4:0];
        rx = int'(ins[7:5]);
        ry = int'(ins[10:8]);
        haz = v && m_ex_v && m_ex_i[4:0] == 5'b00100 &&
              ((rd_x(op) && rx == dest(m_ex_i)) || (rd_y(op) && ry == dest(m_ex_i)));
        e_st = 0; e_bu = 0; e_fl = 0;
        if (st)                e_st = 1;
        else if (br)           begin e_fl = 1; e_bu = 1; end
        else if (m_flush_next) begin e_fl = 1; e_bu = 1; end
        else if (haz)          begin e_st = 1; e_bu = 1; end
        e_fx = (v && rd_x(op)) ? m_fwd(rx) : 2'b00;
        e_fy = (v && rd_y(op)) ? m_fwd(ry) : 2'b00;
        check("stall_fd", o_st, e_st);
        check("bubble_ex", o_bu, e_bu);
        check("flush", o_fl, e_fl);
        check("fwd_x", o_fx, e_fx);
        check("fwd_y", o_fy, e_fy);
        check("stall_count", o_cnt, m_count[15:0]);
        @(posedge clk);
        if (!st) begin
            m_wb_v = m_ex_v; m_wb_i = m_ex_i;
            m_ex_v = v && !e_bu && !e_fl; m_ex_i = ins;
            m_flush_next = br;
        end
        if (e_st && m_count < 65535) m_count++;
    endtask

    initial begin
        logic [15:0] c0;
        // Reset state, with inputs that would otherwise stall and flush
        reset = 1'b1;
        bus.i_d_valid = 1; bus.i_d_instr = mk(5'b00001, 1, 1);
        bus.i_branch_taken = 1; bus.i_ex_stall_req = 1;
        #2;
        capture();
        check("rst_stall", o_st, 0); check("rst_bubble", o_bu, 0); check("rst_flush", o_fl, 0);
        check("rst_fwd_x", o_fx, 0); check("rst_fwd_y", o_fy, 0); check("rst_count", o_cnt, 0);
        @(negedge clk);
        reset = 1'b0;
        bus.i_d_valid = 0; bus.i_branch_taken = 0; bus.i_ex_stall_req = 0;
        model_reset();

        // EX then WB forwarding
        step(1, mk(5'b00001, 1, 0), 0, 0);
        step(1, mk(5'b00001, 2, 1), 0, 0);
        check("fwd_ex_y", o_fy, 2'b01);
        step(1, mk(5'b00011, 1, 6), 0, 0);
        check("fwd_wb_x", o_fx, 2'b10);

        // Load-use stall
        step(1, mk(5'b00100, 3, 4), 0, 0);
        step(1, mk(5'b00001, 5, 3), 0, 0);
        check("lduse_stall", o_st, 1); check("lduse_bubble", o_bu, 1);
        step(1, mk(5'b00001, 5, 3), 0, 0);
        check("lduse_fwd_y", o_fy, 2'b10); check("lduse_count", o_cnt, 1);
        step(0, 16'h0000, 0, 0);

        // Branch overrides load-use, second slot also flushed
        step(1, mk(5'b00100, 3, 4), 0, 0);
        step(1, mk(5'b00001, 5, 3), 1, 0);
        check("br_flush", o_fl, 1); check("br_stall", o_st, 0); check("br_bubble", o_bu, 1);
        step(1, mk(5'b00001, 2, 2), 0, 0);
        check("flush2", o_fl, 1); check("flush2_bubble", o_bu, 1);
        step(1, mk(5'b00001, 2, 2), 0, 0);
        check("flush_done", o_fl, 0);

        // Memory stall freezes the scoreboard
        step(1, mk(5'b00001, 1, 0), 0, 0);
        step(1, mk(5'b00001, 2, 1), 0, 1);
        c0 = o_cnt;
        check("memstall_fwd", o_fy, 2'b01);
        step(1, mk(5'b00001, 2, 1), 1, 1);
        check("memstall_br_wait", o_fl, 0);
        step(1, mk(5'b00001, 2, 1), 0, 1);
        step(1, mk(5'b00001, 2, 1), 0, 0);
        check("memstall_release_fwd", o_fy, 2'b01);
        check("memstall_count", o_cnt, c0 + 16'd3);

        // Reset mid-LDSTALL
        step(1, mk(5'b00100, 3, 4), 0, 0);
        @(negedge clk);
        bus.i_d_valid = 1; bus.i_d_instr = mk(5'b00001, 5, 3);
        bus.i_branch_taken = 0; bus.i_ex_stall_req = 0;
        #2;
        capture();
        check("pre_rst_stall", o_st, 1);
        reset = 1'b1;
        #1;
        capture();
        check("arst_stall", o_st, 0); check("arst_bubble", o_bu, 0); check("arst_flush", o_fl, 0);
        check("arst_fwd_y", o_fy, 0); check("arst_count", o_cnt, 0);
        @(negedge clk);
        reset = 1'b0;
        bus.i_d_valid = 0;
        model_reset();
        step(1, mk(5'b00001, 5, 3), 0, 0);
        check("post_rst_stall", o_st, 0);

        // Random traffic against the model
        for (int i = 0; i < 2000; i++) begin
            logic [4:0] op;
            op = pool[$urandom_range(0, 15)];
            step($urandom_range(0, 99) < 85, mk(op, $urandom_range(0, 3), $urandom_range(0, 3)),
                 $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 10);
        end

        // Counter saturation
        for (int i = 0; i < 70000; i++)
            step(0, 16'h0000, 0, 1);
        check("sat_count", o_cnt, 16'hFFFF);
        step(0, 16'h0000, 0, 1);
        step(0, 16'h0000, 0, 0);
        check("sat_hold", o_cnt, 16'hFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 The block SHALL have one clock, clk; reset is asynchronous and active-high, named reset.
REQ-002 The block SHALL have these ports:
  clk  in  1  clock, all state updates on rising edge
  reset  in  1  async active-high reset
  i_d_valid  in  1  decode stage holds a valid instruction
  i_d_instr  in  16  decode-stage instruction; opcode [4:0], Rx [7:5], Ry [10:8]
  i_branch_taken  in  1  EX-stage instruction redirects PC this cycle
  i_ex_stall_req  in  1  EX-stage memory access not complete, hold whole pipe
  o_stall_fd  out  1  hold fetch and decode registers
  o_bubble_ex  out  1  load NOP into EX instead of decode instruction
  o_flush  out  1  kill instructions in fetch and decode
  o_fwd_x  out  2  Rx operand source: 00 RF, 01 EX result, 10 WB data
  o_fwd_y  out  2  Ry operand source, same encoding
  o_stall_count  out  16  saturating count of cycles with o_stall_fd=1

Function
REQ-003 Writers SHALL be mv 00000, add 00001, sub 00010, ld 00100, mvi 10000, addi 10001, subi 10010, mvhi 10110; destination Rx; call 01100 and 11100 SHALL write r7.
REQ-004 Rx readers SHALL be add, sub, cmp 00011, st 00101, addi, subi, cmpi 10011, mvhi, jr/jz/jn register forms 01000/01001/01010; Ry readers SHALL be mv, add, sub, cmp, ld, st.
REQ-005 Scoreboard SHALL hold two entries, EX and WB, each {valid, wr, dst[2:0], is_ld}.
REQ-006 On each clock with no hold, EX entry SHALL be loaded from decoded i_d_instr when i_d_valid=1 and no bubble/flush, otherwise cleared; WB entry SHALL take the old EX entry.
REQ-007 While i_ex_stall_req=1 both entries SHALL hold; o_stall_fd=1, o_bubble_ex=0.
REQ-008 Load-use hazard: decode reads register r, EX entry valid, wr, is_ld, dst=r -> o_stall_fd=1, o_bubble_ex=1 for exactly one cycle (state LDSTALL); the next cycle reuses the WB forward.
REQ-009 FSM states SHALL be RUN, LDSTALL, FLUSH; RUN->LDSTALL on REQ-008 hazard; LDSTALL->RUN after one cycle; any state->FLUSH on i_branch_taken; FLUSH->RUN after one cycle.
REQ-010 i_branch_taken SHALL drive o_flush=1 combinationally that cycle and o_bubble_ex=1; flush SHALL override a simultaneous load-use stall (o_stall_fd=0).
REQ-011 In FLUSH state o_bubble_ex=1 and o_flush=1 (second killed slot); no new EX entry is loaded.
REQ-012 i_ex_stall_req SHALL take priority over i_branch_taken; branch is acted on the first cycle i_ex_stall_req=0.
REQ-013 Forwarding per operand: EX entry valid, wr, !is_ld, dst match -> 01; else WB entry valid, wr, dst match -> 10; else 00; non-read operands SHALL output 00.
REQ-014 Forward and stall outputs SHALL be combinational from scoreboard, state and inputs; zero-cycle latency.
REQ-015 o_stall_count SHALL increment each cycle o_stall_fd=1 and saturate at 16'hFFFF.
REQ-016 i_d_valid=0 SHALL produce no hazard, o_fwd_x=o_fwd_y=00.

Reset
REQ-017 While reset=1: state RUN, both scoreboard entries invalid, o_stall_count=0, o_stall_fd=0, o_bubble_ex=0, o_flush=0, o_fwd_x=o_fwd_y=00.
REQ-018 Reset asserted mid-LDSTALL or mid-FLUSH SHALL abort immediately; first cycle after release behaves as RUN with empty scoreboard.

Verification
REQ-019 add r1 (Rx=1) then add r2,r1 -> second cycle o_fwd_y=01; next cycle with unrelated instr reading r1 -> o_fwd_x or o_fwd_y=10.
REQ-020 ld r3,[r4] then add r5,r3 -> one cycle o_stall_fd=1, o_bubble_ex=1, then o_fwd_y=10, o_stall_count=1.
REQ-021 ld r3 in EX, decode reads r3, i_branch_taken=1 same cycle -> o_flush=1, o_stall_fd=0, FSM FLUSH, next cycle o_flush=1, then RUN.
REQ-022 i_ex_stall_req=1 for 3 cycles with add in EX -> scoreboard frozen, o_stall_count=3, forwarding unchanged on release.
REQ-023 Drive 70000 stall cycles -> o_stall_count=16'hFFFF, holds.
REQ-024 Assert reset during LDSTALL -> all outputs 0 asynchronously, scoreboard empty, o_stall_count=0.
